// File: rtl/rs_sched_pkg.sv
// Shared types and defaults for the encode_rs request scheduler.
package rs_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_RUN   = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_e;

   localparam int NUM_REQ_DEF = 4;
   localparam int TIMEOUT_DEF = 4096;
   localparam int CNT_W_DEF   = 32;
   localparam int SEL_W       = $clog2(NUM_REQ_DEF);

   // Owner-index width for a given requester count; never narrower than one bit.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rs_encode_scheduler_rr_pick.sv
// Round-robin picker: first requester after 'last', wrapping modulo N.
module rr_pick
   import rs_sched_pkg::*;
#(
   parameter int N = NUM_REQ_DEF,
   parameter int W = sel_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [N-1:0] grant,
   output logic [W-1:0] index
);

   // Scan last+1 .. last+N and take the first asserted request.
   always_comb begin
      logic         found;
      logic [W-1:0] cand;
      int           pos;
      grant = '0;
      index = '0;
      found = 1'b0;
      cand  = '0;
      pos   = 0;
      for (int off = 1; off <= N; off++) begin
         pos  = (int'(last) + off) % N;
         cand = W'(pos);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            index       = cand;
         end
      end
   end

endmodule

// File: rtl/rs_encode_scheduler.sv
// Arbitrates NUM_REQ requesters onto one encode_rs core, with a watchdog
// that abandons a hung job and drains the core before re-arbitrating.
module rs_encode_scheduler
   import rs_sched_pkg::*;
#(
   parameter int NUM_REQ        = NUM_REQ_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [NUM_REQ-1:0]         rsp_done,
   output logic [NUM_REQ-1:0]         rsp_error,
   output logic [$clog2(NUM_REQ)-1:0] sel,
   output logic                       enc_ap_start,
   input  logic                       enc_ap_ready,
   input  logic                       enc_ap_done,
   output logic                       busy,
   output logic [CNT_W-1:0]           job_count,
   output logic [15:0]                timeout_count
);

   localparam int SW   = $clog2(NUM_REQ);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES - 1);

   state_e             state_q;
   logic [NUM_REQ-1:0] req_ready_q, rsp_done_q, rsp_error_q;
   logic [SW-1:0]      sel_q, last_q;
   logic               start_q;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [CNT_W-1:0]   job_cnt_q, job_cnt_d;
   logic [15:0]        to_cnt_q, to_cnt_d;

   logic [NUM_REQ-1:0] gnt, owner_oh;
   logic [SW-1:0]      gnt_idx;
   logic               finish_ok;

   rr_pick #(.N(NUM_REQ), .W(SW)) u_pick (
      .req   (req_valid),
      .last  (last_q),
      .grant (gnt),
      .index (gnt_idx)
   );

   // In START the core only counts as finished once it has also accepted the start.
   assign finish_ok = enc_ap_done && ((state_q == S_RUN) || enc_ap_ready);
   assign owner_oh  = NUM_REQ'(1) << sel_q;
   assign wd_d      = wd_q + 1'b1;
   assign job_cnt_d = (&job_cnt_q) ? job_cnt_q : job_cnt_q + 1'b1;
   assign to_cnt_d  = (&to_cnt_q) ? to_cnt_q : to_cnt_q + 1'b1;

   // Scheduler FSM; every pulse and strobe is registered here.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= S_IDLE;
         req_ready_q <= '0;
         rsp_done_q  <= '0;
         rsp_error_q <= '0;
         sel_q       <= '0;
         last_q      <= SW'(NUM_REQ - 1);
         start_q     <= 1'b0;
         wd_q        <= '0;
         job_cnt_q   <= '0;
         to_cnt_q    <= '0;
      end else begin
         req_ready_q <= '0;
         rsp_done_q  <= '0;
         rsp_error_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (|req_valid) begin
                  req_ready_q <= gnt;
                  sel_q       <= gnt_idx;
                  start_q     <= 1'b1;
                  wd_q        <= '0;
                  state_q     <= S_START;
               end
            end
            S_START, S_RUN: begin
               if (finish_ok) begin
                  // done wins even on the watchdog's last cycle
                  rsp_done_q <= owner_oh;
                  job_cnt_q  <= job_cnt_d;
                  start_q    <= 1'b0;
                  state_q    <= S_DONE;
               end else if (wd_q == WD_LIM) begin
                  rsp_error_q <= owner_oh;
                  to_cnt_q    <= to_cnt_d;
                  start_q     <= 1'b0;
                  state_q     <= S_DRAIN;
               end else begin
                  wd_q <= wd_d;
                  if (state_q == S_START && enc_ap_ready) begin
                     start_q <= 1'b0;
                     state_q <= S_RUN;
                  end
               end
            end
            S_DONE: begin
               last_q  <= sel_q;
               state_q <= S_IDLE;
            end
            S_DRAIN: begin
               // core must finish the abandoned job before it can be reused
               if (enc_ap_done) begin
                  last_q  <= sel_q;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready     = req_ready_q;
   assign rsp_done      = rsp_done_q;
   assign rsp_error     = rsp_error_q;
   assign sel           = sel_q;
   assign enc_ap_start  = start_q;
   assign busy          = (state_q != S_IDLE);
   assign job_count     = job_cnt_q;
   assign timeout_count = to_cnt_q;

endmodule
